// File: rtl/time_package.sv
`default_nettype none
// ============================================================================
// Package     : time_package
// Description : Emulator time representation shared by time-stamped blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package time_package;

  localparam int TIME_POINT = 8;

  // Unsigned fixed point; TIME_POINT of the bits are fractional.
  typedef logic [31:0] TIME_FORMAT;

endpackage : time_package
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Generic synchronous FIFO with combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_full  = DEPTH[c_ptr_w:0];

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == c_full);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

endmodule : sample_fifo
`default_nettype wire

// File: rtl/dac_player.sv
`default_nettype none
// ============================================================================
// Module      : dac_player
// Description : Replays buffered (time, value) samples onto a registered
//               signed output once emulator time reaches each timestamp.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_player
  import time_package::*;
#(
  parameter int                         sig_bits  = 1,
  parameter int                         sig_point = 1,
  parameter int                         DEPTH     = 8,
  parameter logic signed [sig_bits-1:0] INIT      = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$bits(TIME_FORMAT)-1:0] time_curr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$bits(TIME_FORMAT)-1:0] in_time,
  input  logic signed [sig_bits-1:0]    in_sig,
  output logic signed [sig_bits-1:0]    sig,
  output logic                          sig_update,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic                          order_err
);

  localparam int c_time_w  = $bits(TIME_FORMAT);
  localparam int c_entry_w = c_time_w + sig_bits;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || sig_point > sig_bits ||
      TIME_POINT > c_time_w) begin : g_param_check
    $error("dac_player: invalid parameterisation");
  end

  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic [c_entry_w-1:0]       w_head;
  logic [c_time_w-1:0]        w_head_time;
  logic signed [sig_bits-1:0] w_head_sig;

  logic signed [sig_bits-1:0] r_sig;
  logic                       r_sig_update;
  logic                       r_order_err;
  logic                       r_have_last;
  logic [c_time_w-1:0]        r_last_time;

  assign w_head_time = w_head[c_entry_w-1 -: c_time_w];
  assign w_head_sig  = w_head[sig_bits-1:0];
  assign in_ready    = !w_full;
  assign w_push      = in_valid && !w_full;

  // Written as an if so that an unknown time_curr resolves to "not due".
  always_comb begin
    w_pop = 1'b0;
    if (!w_empty && (w_head_time <= time_curr)) w_pop = 1'b1;
  end

  sample_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({in_time, in_sig}),
    .pop   (w_pop),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig        <= INIT;
      r_sig_update <= 1'b0;
      r_order_err  <= 1'b0;
      r_have_last  <= 1'b0;
      r_last_time  <= '0;
    end else begin
      if (w_pop) begin
        r_sig        <= w_head_sig;
        r_sig_update <= 1'b1;
      end else begin
        r_sig_update <= 1'b0;
      end
      // Out-of-order entries are flagged but still queued and replayed.
      if (w_push) begin
        if (r_have_last && (in_time < r_last_time)) r_order_err <= 1'b1;
        r_have_last <= 1'b1;
        r_last_time <= in_time;
      end
    end
  end

  assign sig        = r_sig;
  assign sig_update = r_sig_update;
  assign order_err  = r_order_err;

endmodule : dac_player
`default_nettype wire

// File: tb/tb_dac_player.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dac_player
// Description : Self-checking bench for dac_player against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_player;
  import time_package::*;

  localparam int                  SB     = 8;
  localparam int                  DEPTH  = 8;
  localparam int                  TW     = $bits(TIME_FORMAT);
  localparam int                  CW     = $clog2(DEPTH) + 1;
  localparam logic signed [SB-1:0] INIT_V = 8'sd0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [TW-1:0]        time_curr = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [TW-1:0]        in_time = '0;
  logic signed [SB-1:0] in_sig = '0;
  logic signed [SB-1:0] sig;
  logic                 sig_update;
  logic [CW-1:0]        fifo_count;
  logic                 order_err;

  always #5 clk = ~clk;

  dac_player #(
    .sig_bits  (SB),
    .sig_point (4),
    .DEPTH     (DEPTH),
    .INIT      (INIT_V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .time_curr  (time_curr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_time    (in_time),
    .in_sig     (in_sig),
    .sig        (sig),
    .sig_update (sig_update),
    .fifo_count (fifo_count),
    .order_err  (order_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a plain queue of pending samples
  TIME_FORMAT           mq_t[$];
  logic signed [SB-1:0] mq_v[$];
  logic signed [SB-1:0] m_sig = INIT_V;
  bit                   m_upd = 0;
  bit                   m_err = 0;
  bit                   m_have = 0;
  bit                   m_on = 0;
  bit                   m_can_push;
  TIME_FORMAT           m_last = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq_t.delete();
      mq_v.delete();
      m_sig  = INIT_V;
      m_upd  = 0;
      m_err  = 0;
      m_have = 0;
      m_on   = 1;
    end else if (m_on) begin
      m_can_push = in_valid && (mq_t.size() < DEPTH);
      m_upd = 0;
      if (mq_t.size() > 0 && mq_t[0] <= time_curr) begin
        m_sig = mq_v.pop_front();
        void'(mq_t.pop_front());
        m_upd = 1;
      end
      if (m_can_push) begin
        if (m_have && in_time < m_last) m_err = 1;
        m_have = 1;
        m_last = in_time;
        mq_t.push_back(in_time);
        mq_v.push_back(in_sig);
      end
    end
  end

  // ---------------- per-cycle compare and update log
  int                   cyc = 0;
  bit                   last_ready = 0;
  int                   log_cyc[$];
  TIME_FORMAT           log_t[$];
  logic signed [SB-1:0] log_v[$];

  always @(negedge clk) begin
    cyc++;
    last_ready = in_ready;
    if (m_on) begin
      chk("sig", sig, m_sig);
      chk("sig_update", sig_update, m_upd);
      chk("fifo_count", fifo_count, mq_t.size());
      chk("in_ready", in_ready, mq_t.size() < DEPTH);
      chk("order_err", order_err, m_err);
    end
    if (sig_update) begin
      log_cyc.push_back(cyc);
      log_t.push_back(time_curr);
      log_v.push_back(sig);
    end
  end

  // ---------------- stimulus helpers
  bit auto_step = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_step) time_curr = time_curr + 10;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_t.delete();
    log_v.delete();
  endtask

  task automatic push(input TIME_FORMAT t, input logic signed [SB-1:0] v);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_time  = t;
    in_sig   = v;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  TIME_FORMAT next_t;

  initial begin
    // Reset state
    do_reset(2);
    chk("rst_sig", sig, 0);
    chk("rst_sig_update", sig_update, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_order_err", order_err, 0);

    // Basic replay with time stepping +10 per cycle
    time_curr = '0;
    auto_step = 1;
    clear_log();
    push(100, 8'sd5);
    push(200, -8'sd3);
    repeat (30) tick();
    auto_step = 0;
    chk("basic_updates", log_v.size(), 2);
    if (log_v.size() == 2) begin
      chk("basic_v0", log_v[0], 5);
      chk("basic_t0", log_t[0], 110);
      chk("basic_v1", log_v[1], -3);
      chk("basic_t1", log_t[1], 210);
    end
    chk("basic_count", fifo_count, 0);

    // Equal and overdue timestamps
    do_reset(1);
    time_curr = 1000;
    clear_log();
    push(50, 8'sd1);
    push(50, 8'sd2);
    chk("equal_ts_legal", order_err, 0);
    push(40, 8'sd3);
    repeat (3) tick();
    chk("order_err_set", order_err, 1);
    chk("overdue_final_sig", sig, 3);
    chk("overdue_updates", log_v.size(), 3);
    if (log_v.size() == 3) begin
      chk("overdue_v0", log_v[0], 1);
      chk("overdue_v1", log_v[1], 2);
      chk("overdue_v2", log_v[2], 3);
      chk("overdue_consecutive", log_cyc[2] - log_cyc[0], 2);
    end

    // Full FIFO, held offer, then drain
    do_reset(1);
    time_curr = '0;
    clear_log();
    for (int i = 0; i < DEPTH; i++) push(1000000, SB'(10 + i));
    chk("full_count", fifo_count, 8);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_time  = 1000000;
    in_sig   = 8'sd99;
    repeat (3) tick();
    chk("full_hold_count", fifo_count, 8);
    chk("full_hold_ready", in_ready, 0);
    time_curr = 1000000;
    tick();
    chk("after_pop_ready", in_ready, 1);
    chk("after_pop_count", fifo_count, 7);
    chk("after_pop_sig", sig, 10);
    tick();
    in_valid = 1'b0;
    chk("push_pop_count", fifo_count, 7);
    repeat (12) tick();
    chk("drain_updates", log_v.size(), 9);
    if (log_v.size() == 9) begin
      for (int i = 0; i < 8; i++) chk("drain_v", log_v[i], 10 + i);
      chk("drain_last", log_v[8], 99);
    end

    // Concurrent push and pop
    do_reset(1);
    time_curr = '0;
    clear_log();
    for (int i = 0; i < 4; i++) push(500, SB'(1 + i));
    time_curr = 500;
    in_valid  = 1'b1;
    in_time   = 500;
    for (int k = 0; k < 6; k++) begin
      in_sig = SB'(20 + k);
      tick();
      chk("concurrent_count", fifo_count, 4);
    end
    in_valid = 1'b0;
    repeat (8) tick();
    chk("concurrent_updates", log_v.size(), 10);
    chk("concurrent_final", sig, 25);

    // Reset mid-operation discards queued samples
    do_reset(1);
    time_curr = '0;
    push(10, 8'sd7);
    time_curr = 10;
    repeat (2) tick();
    chk("mid_sig_before", sig, 7);
    push(20, 8'sd33);
    push(20, 8'sd34);
    push(20, 8'sd35);
    chk("mid_queued", fifo_count, 3);
    clear_log();
    time_curr = 100;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_sig", sig, 0);
    chk("mid_rst_count", fifo_count, 0);
    repeat (10) tick();
    chk("mid_no_replay", log_v.size(), 0);
    chk("mid_sig_after", sig, 0);

    // Randomised traffic against the model
    do_reset(1);
    time_curr = '0;
    next_t = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_ready) begin
        in_valid = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 19) == 0 && next_t > 30)
          next_t = next_t - $urandom_range(0, 30);
        else
          next_t = next_t + $urandom_range(0, 40);
        in_time = next_t;
        in_sig  = SB'($urandom_range(0, 255));
      end
      time_curr = time_curr + $urandom_range(0, 12);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    time_curr = time_curr + 100000;
    repeat (12) tick();
    chk("random_drained", fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_dac_player
`default_nettype wire

// File: doc/dac_player.md
Name: dac_player

Overview:
- Stimulus-side counterpart of the ADC sample logger.
- Accepts a stream of (time, value) samples over a valid/ready interface and buffers them in a small FIFO.
- Drives a signed fixed-point output that takes each buffered value once the emulator's current time reaches that sample's timestamp.
- Sits between a host/memory sample source and the analog model input it excites, e.g. the TX data or an injected noise waveform.

Parameters:
sig_bits, 1, width of the signed output sample
sig_point, 1, binary point position of the output sample (documentation/formatting only; no arithmetic depends on it)
DEPTH, 8, FIFO depth in entries; power of two, at least 2
INIT, 0, signed output value after reset

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
time_curr  input  TIME_FORMAT  current emulator time (unsigned fixed point, TIME_POINT fractional bits)
in_valid  input  1  sample offered
in_ready  output  1  FIFO can accept a sample
in_time  input  TIME_FORMAT  timestamp at which in_sig takes effect
in_sig  input  sig_bits signed  sample value
sig  output  sig_bits signed  replayed output, registered
sig_update  output  1  one-cycle pulse, high in the cycle sig takes a newly popped value
fifo_count  output  $clog2(DEPTH)+1  entries currently buffered
order_err  output  1  sticky: a pushed timestamp was smaller than the previous pushed timestamp

Behaviour:
- Reset: one clock, synchronous, active-high. rst sampled high on a clk edge sets: sig=INIT, sig_update=0, fifo_count=0, order_err=0, pointers=0, have_last=0.
- Reset priority: rst overrides any push or pop in the same cycle. Queued entries are discarded and never applied.
- in_ready = (fifo_count != DEPTH), derived from registered state only; no combinational path from in_valid.
- Push: occurs on in_valid && in_ready. Entry {in_time, in_sig} is written at the write pointer; wptr increments modulo DEPTH.
- The source must hold in_valid/in_time/in_sig stable until accepted.
- Pop condition: fifo_count != 0 and head_time <= time_curr (unsigned compare over the full TIME_FORMAT width).
- Pop effect, on the clock edge: sig <= head_sig, sig_update <= 1, rptr increments modulo DEPTH. Otherwise sig holds and sig_update <= 0.
- At most one pop per cycle. Several entries already due drain on consecutive cycles, one value per cycle.
- No bypass: a sample pushed on edge N is at the head no earlier than the cycle after N. Its earliest effect on sig is at edge N+1.
- Latency from time_curr first satisfying head_time <= time_curr to sig changing: exactly one edge.
- Simultaneous push and pop: fifo_count unchanged; both pointers advance.
- Full and due: pop proceeds, no push that cycle (in_ready was low); in_ready goes high the next cycle.
- Empty: sig holds its last value indefinitely; sig_update stays 0.
- Ordering check: each push compares in_time with the last pushed time, tracked by have_last/last_time.
  - Strictly smaller sets order_err, which stays set until rst.
  - The offending entry is still accepted and replayed in FIFO order.
  - Equal timestamps are legal.
- Time wrap-around is not supported. TIME_FORMAT is sized so that time_curr never wraps within a run.
- time_curr containing X (before time starts): treat as not due; no pop in that cycle.

Decomposition:
- time_package (existing) supplies TIME_FORMAT and TIME_POINT; no new typedefs there.
- Add to time_package: typedef for the entry struct {TIME_FORMAT t; logic signed [..] v} is not possible generically. Instead pack the entry as a flat vector of width $bits(TIME_FORMAT)+sig_bits inside dac_player.
- Sub-module sample_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst, push, din, pop, dout (head, combinational read), count, full, empty.
  - dac_player owns the compare, output register, ordering check and handshake.

Test Plan:
1. Reset: rst high 2 cycles with INIT=0 -> sig=0, sig_update=0, in_ready=1, fifo_count=0, order_err=0.
2. Basic replay: time_curr starts at 0 and steps +10 per cycle; push (100,5) then (200,-3) -> sig becomes 5 on the edge after time_curr==100 and -3 on the edge after time_curr==200; exactly two sig_update pulses; fifo_count returns to 0.
3. Equal/overdue times: push (50,1), (50,2), (40,3) while time_curr=1000 -> order_err=1; sig takes 1, 2, 3 on three consecutive edges with sig_update high all three cycles; final sig=3.
4. Full: DEPTH=8; push 8 entries all at t=10^6 while time_curr=0 -> in_ready low after the 8th push and fifo_count=8; a held in_valid is not accepted. Set time_curr=10^6 -> one pop per cycle, with in_ready high the cycle after the first pop.
5. Concurrent push/pop: 4 entries queued, head due, in_valid held high -> fifo_count stays 4 each cycle while pops continue.
6. Reset mid-operation: 3 entries queued, sig=7; assert rst one cycle with time_curr past all timestamps -> sig=INIT, fifo_count=0, and none of the 3 values ever appears on sig.
